// File: rtl/servo_pwm_pkg.sv
// servo_pwm_pkg: shared widths, servo timing constants and the per-frame slew step function.
package servo_pwm_pkg;
  localparam int DEF_CNT_W   = 24;
  localparam int DEF_STEP_W  = 16;
  localparam int PERIOD_20MS = 519999;
  localparam int PULSE_1MS   = 26000;
  localparam int PULSE_2MS   = 52000;
  // One bit of headroom so active+step and active-step never wrap.
  function automatic logic [31:0] slew_next(input logic [31:0] tgt, input logic [31:0] act, input logic [31:0] step);
    logic [32:0] t, a, s, r;
    t = {1'b0, tgt};
    a = {1'b0, act};
    s = {1'b0, step};
    r = s == '0 ? t : t > a ? (t - a > s ? a + s : t) : (a - t > s ? a - s : t);
    return r[31:0];
  endfunction
endpackage

// File: rtl/servo_pwm_ch.sv
// servo_pwm_ch: one PWM channel with frame-committed width/enable, slew limiting and a two-stage output pipeline.
module servo_pwm_ch
  import servo_pwm_pkg::*;
#(
  parameter int CNT_W  = DEF_CNT_W,
  parameter int STEP_W = DEF_STEP_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              boundary,
  input  logic              run,
  input  logic              wr,
  input  logic [CNT_W-1:0]  wr_pulse,
  input  logic [CNT_W-1:0]  cnt,
  input  logic              enable,
  input  logic [STEP_W-1:0] slew_step,
  output logic              pwm,
  output logic              settled
);
  logic [CNT_W-1:0] target, active, next_active;
  logic en_act, raw, state;
  assign next_active = CNT_W'(slew_next(32'(target), 32'(active), 32'(slew_step)));
  assign raw = run && en_act && cnt < active;
  assign settled = active == target;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      target <= '0;
      active <= '0;
      en_act <= 1'b0;
      state  <= 1'b0;
      pwm    <= 1'b0;
    end else begin
      if (wr) target <= wr_pulse;
      if (boundary) begin
        active <= next_active;
        en_act <= enable;
      end
      state <= raw;
      pwm   <= state;
    end
  end
endmodule

// File: rtl/servo_pwm_multi.sv
// servo_pwm_multi: shared frame counter, write decode and frame_start pipeline driving NUM_CH PWM channels.
module servo_pwm_multi
  import servo_pwm_pkg::*;
#(
  parameter int NUM_CH = 4,
  parameter int CNT_W  = DEF_CNT_W,
  parameter int STEP_W = DEF_STEP_W,
  localparam int CH_W  = NUM_CH > 1 ? $clog2(NUM_CH) : 1
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [CNT_W-1:0]  period,
  input  logic              wr_en,
  input  logic [CH_W-1:0]   wr_ch,
  input  logic [CNT_W-1:0]  wr_pulse,
  input  logic [NUM_CH-1:0] ch_enable,
  input  logic [STEP_W-1:0] slew_step,
  output logic [NUM_CH-1:0] pwm_out,
  output logic              frame_start,
  output logic [NUM_CH-1:0] settled
);
  logic [1:0] rsync;
  logic rst_n, run, boundary, fs0;
  logic [CNT_W-1:0] cnt;
  // Reset asserts immediately and releases two clocks later, in step with clk.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) rsync <= 2'b00;
    else rsync <= {rsync[0], 1'b1};
  end
  assign rst_n = rsync[1];
  assign run = period != '0;
  assign boundary = run && cnt >= period;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt         <= '0;
      fs0         <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      cnt         <= (boundary || !run) ? '0 : cnt + 1'b1;
      fs0         <= run && cnt == '0;
      frame_start <= fs0;
    end
  end
  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    servo_pwm_ch #(.CNT_W(CNT_W), .STEP_W(STEP_W)) u_ch (
      .clk      (clk),
      .rst_n    (rst_n),
      .boundary (boundary),
      .run      (run),
      .wr       (wr_en && wr_ch == CH_W'(i)),
      .wr_pulse (wr_pulse),
      .cnt      (cnt),
      .enable   (ch_enable[i]),
      .slew_step(slew_step),
      .pwm      (pwm_out[i]),
      .settled  (settled[i])
    );
  end
endmodule
